// File: rtl/fft_peak_tracker_pkg.sv
// Shared defaults and frame helpers for the FFT magnitude / peak tracker.
package fft_peak_tracker_pkg;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_ADDR_W   = 8;
  localparam int unsigned DEF_NUM_PEAK = 4;
  localparam int unsigned DEF_MIN_BIN  = 1;

  // Last bin that carries data in a frame: N-1, or N/2-1 in half-spectrum mode.
  function automatic logic is_last_used(input int unsigned bin, input logic half,
                                        input int unsigned addr_w);
    int unsigned last;
    last = half ? ((32'd1 << (addr_w - 1)) - 32'd1) : ((32'd1 << addr_w) - 32'd1);
    return bin == last;
  endfunction

endpackage

// File: rtl/fft_peak_tracker_if.sv
// Input bin stream and output magnitude stream of the peak tracker.
interface fft_peak_tracker_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
);
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_re;
  logic signed [DATA_W-1:0] s_im;
  logic                     s_last;
  logic                     m_valid;
  logic                     m_ready;
  logic        [DATA_W-1:0] m_mag;
  logic        [ADDR_W-1:0] m_bin;

  modport master (
    output s_valid, s_re, s_im, s_last, m_ready,
    input  s_ready, m_valid, m_mag, m_bin
  );

  modport slave (
    input  s_valid, s_re, s_im, s_last, m_ready,
    output s_ready, m_valid, m_mag, m_bin
  );
endinterface

// File: rtl/fft_peak_tracker_mag_approx.sv
// Combinational shift-add magnitude approximation from absolute re/im values.
module fft_mag_approx #(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] abs_re,
  input  logic [DATA_W-1:0] abs_im,
  output logic [DATA_W-1:0] mag
);
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   est;

  always_comb begin
    a   = (abs_re >= abs_im) ? abs_re : abs_im;
    b   = (abs_re >= abs_im) ? abs_im : abs_re;
    sum = {1'b0, a} + {1'b0, b};
    est = sum - (sum >> 2);
    // Inputs are at most 2^(DATA_W-1)-1, so est never exceeds the DATA_W range.
    mag = (b <= (a >> 1)) ? a : est[DATA_W-1:0];
  end
endmodule

// File: rtl/fft_peak_tracker.sv
// Streaming FFT bin magnitude with per-frame top-K peak tracking (DC/low bins excluded).
module fft_peak_tracker
  import fft_peak_tracker_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_PEAK = DEF_NUM_PEAK,
  parameter int unsigned MIN_BIN  = DEF_MIN_BIN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_half,
  fft_peak_tracker_if.slave            bus,
  output logic                         pk_valid,
  output logic [NUM_PEAK*ADDR_W-1:0]   pk_bin,
  output logic [NUM_PEAK*DATA_W-1:0]   pk_mag,
  output logic                         len_err
);
  localparam logic [ADDR_W-1:0] LAST_BIN = '1;

  logic              adv, acc, half_eff, half_q, drop;
  logic [ADDR_W-1:0] cnt;
  logic              s1_valid, s1_half;
  logic [ADDR_W-1:0] s1_bin;
  logic [DATA_W-1:0] s1_re, s1_im;
  logic [DATA_W-1:0] s2_mag_next;
  logic              load2, track_en, publish;

  logic              gt       [NUM_PEAK];
  logic [DATA_W-1:0] w_mag    [NUM_PEAK];
  logic [ADDR_W-1:0] w_bin    [NUM_PEAK];
  logic [DATA_W-1:0] n_mag    [NUM_PEAK];
  logic [ADDR_W-1:0] n_bin    [NUM_PEAK];
  logic [DATA_W-1:0] pk_mag_q [NUM_PEAK];
  logic [ADDR_W-1:0] pk_bin_q [NUM_PEAK];

  function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] x);
    if (x == {1'b1, {(DATA_W-1){1'b0}}}) return {1'b0, {(DATA_W-1){1'b1}}};
    else if (x[DATA_W-1])                return (~x) + 1'b1;
    else                                 return x;
  endfunction

  assign adv         = ~bus.m_valid | bus.m_ready;
  assign bus.s_ready = adv & ~rst;
  assign acc         = bus.s_valid & bus.s_ready;
  // Half mode is latched with bin 0, but bin 0 itself must follow the live input.
  assign half_eff    = (cnt == '0) ? cfg_half : half_q;
  assign drop        = half_eff & cnt[ADDR_W-1];

  assign load2    = adv & s1_valid;
  assign track_en = load2 && (32'(s1_bin) >= MIN_BIN);
  assign publish  = load2 && is_last_used(32'(s1_bin), s1_half, ADDR_W);

  fft_mag_approx #(.DATA_W(DATA_W)) u_mag (
    .abs_re (s1_re),
    .abs_im (s1_im),
    .mag    (s2_mag_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      half_q      <= 1'b0;
      s1_valid    <= 1'b0;
      s1_half     <= 1'b0;
      s1_bin      <= '0;
      s1_re       <= '0;
      s1_im       <= '0;
      bus.m_valid <= 1'b0;
      bus.m_mag   <= '0;
      bus.m_bin   <= '0;
      len_err     <= 1'b0;
      pk_valid    <= 1'b0;
    end else begin
      len_err  <= acc & (bus.s_last != (cnt == LAST_BIN));
      pk_valid <= publish;
      if (acc) begin
        cnt <= cnt + 1'b1;
        if (cnt == '0) half_q <= cfg_half;
      end
      if (adv) begin
        s1_valid    <= acc & ~drop;
        s1_half     <= half_eff;
        s1_bin      <= cnt;
        s1_re       <= abs_sat(bus.s_re);
        s1_im       <= abs_sat(bus.s_im);
        bus.m_valid <= s1_valid;
        if (s1_valid) begin
          bus.m_mag <= s2_mag_next;
          bus.m_bin <= s1_bin;
        end
      end
    end
  end

  // List is kept sorted descending, so gt[] is monotonic and the insertion slot is
  // the first j with gt[j]; slots after it take their predecessor's entry.
  for (genvar j = 0; j < NUM_PEAK; j++) begin : g_slot
    assign gt[j] = track_en && (s2_mag_next > w_mag[j]);

    if (j == 0) begin : g_head
      assign n_mag[j] = gt[j] ? s2_mag_next : w_mag[j];
      assign n_bin[j] = gt[j] ? s1_bin      : w_bin[j];
    end else begin : g_tail
      assign n_mag[j] = !gt[j] ? w_mag[j] : (gt[j-1] ? w_mag[j-1] : s2_mag_next);
      assign n_bin[j] = !gt[j] ? w_bin[j] : (gt[j-1] ? w_bin[j-1] : s1_bin);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        w_mag[j]    <= '0;
        w_bin[j]    <= '0;
        pk_mag_q[j] <= '0;
        pk_bin_q[j] <= '0;
      end else if (publish) begin
        w_mag[j]    <= '0;
        w_bin[j]    <= '0;
        pk_mag_q[j] <= n_mag[j];
        pk_bin_q[j] <= n_bin[j];
      end else if (track_en) begin
        w_mag[j] <= n_mag[j];
        w_bin[j] <= n_bin[j];
      end
    end
  end

  always_comb begin
    pk_bin = '0;
    pk_mag = '0;
    for (int unsigned j = 0; j < NUM_PEAK; j++) begin
      pk_bin[j*ADDR_W +: ADDR_W] = pk_bin_q[j];
      pk_mag[j*DATA_W +: DATA_W] = pk_mag_q[j];
    end
  end
endmodule

// File: tb/tb_fft_peak_tracker.sv
// Directed bench for fft_peak_tracker (N=256, K=4, 16-bit data, MIN_BIN=1).
module tb_fft_peak_tracker;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_half;
  logic        pk_valid;
  logic [31:0] pk_bin;
  logic [63:0] pk_mag;
  logic        len_err;

  fft_peak_tracker_if #(.DATA_W(16), .ADDR_W(8)) bus ();

  fft_peak_tracker #(.DATA_W(16), .ADDR_W(8), .NUM_PEAK(4), .MIN_BIN(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_half (cfg_half),
    .bus      (bus),
    .pk_valid (pk_valid),
    .pk_bin   (pk_bin),
    .pk_mag   (pk_mag),
    .len_err  (len_err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   beats = 0;
  int   pkv = 0;
  int   lerr = 0;
  int   seen   [256];
  int   mag_at [256];
  int   fr_re  [256];
  int   fr_im  [256];
  logic fr_last[256];
  logic rand_en = 1'b0;
  int   pkv0, lerr0;

  always @(negedge clk) begin
    if (bus.m_valid && bus.m_ready) begin
      beats++;
      seen[bus.m_bin]++;
      mag_at[bus.m_bin] = int'(bus.m_mag);
    end
    if (pk_valid) pkv++;
    if (len_err)  lerr++;
  end

  always @(posedge clk) begin
    #1;
    bus.m_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_mag(input int re, input int im);
    int ar, ai, a, b;
    ar = (re < 0) ? -re : re;
    ai = (im < 0) ? -im : im;
    if (ar > 32767) ar = 32767;
    if (ai > 32767) ai = 32767;
    a = (ar > ai) ? ar : ai;
    b = (ar > ai) ? ai : ar;
    if (2 * b <= a) return a;
    return (a + b) - (a + b) / 4;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 256; i++) begin
      fr_re[i] = 0; fr_im[i] = 0; fr_last[i] = (i == 255);
      seen[i] = 0; mag_at[i] = -1;
    end
    beats = 0;
    pkv0  = pkv;
    lerr0 = lerr;
  endtask

  task automatic send_bin(input int idx);
    logic rdy;
    logic got;
    bus.s_valid = 1'b1;
    bus.s_re    = 16'(fr_re[idx]);
    bus.s_im    = 16'(fr_im[idx]);
    bus.s_last  = fr_last[idx];
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      rdy = bus.s_ready;
      @(posedge clk);
      #1;
      if (rdy) got = 1'b1;
    end
    if (!got) check("accept_timeout", 64'(got), 64'd1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic run_frame(input int n);
    for (int i = 0; i < n; i++) send_bin(i);
    tick(8);
  endtask

  initial begin
    rst = 1'b1; cfg_half = 1'b0;
    bus.s_valid = 1'b0; bus.s_re = '0; bus.s_im = '0; bus.s_last = 1'b0; bus.m_ready = 1'b1;
    tick(3);
    check("rst_s_ready",  64'(bus.s_ready), 64'd0);
    check("rst_m_valid",  64'(bus.m_valid), 64'd0);
    check("rst_pk_valid", 64'(pk_valid),    64'd0);
    check("rst_pk_bin",   64'(pk_bin),      64'd0);
    check("rst_pk_mag",   pk_mag,           64'd0);
    check("rst_len_err",  64'(len_err),     64'd0);
    rst = 1'b0;
    tick(1);
    check("idle_s_ready", 64'(bus.s_ready), 64'd1);

    // Single tone at bin 10
    clear_frame();
    fr_re[10] = 1000;
    run_frame(256);
    check("t1_beats",   64'(beats),       64'd256);
    check("t1_pkv",     64'(pkv - pkv0),  64'd1);
    check("t1_len_err", 64'(lerr - lerr0), 64'd0);
    check("t1_m_mag10", 64'(mag_at[10]),  64'd1000);
    check("t1_pk_bin",  64'(pk_bin),      64'h0000_000A);
    check("t1_pk_mag",  pk_mag,           64'd1000);

    // Five tones, smallest falls off the list
    clear_frame();
    fr_re[3] = 100; fr_re[7] = 500; fr_re[20] = 300; fr_re[50] = 900; fr_re[90] = 200;
    run_frame(256);
    check("t2_pkv",    64'(pkv - pkv0), 64'd1);
    check("t2_pk_bin", 64'(pk_bin),     64'h5A14_0732);
    check("t2_pk_mag", pk_mag,          64'h00C8_012C_01F4_0384);

    // DC exclusion, tie ordering, both magnitude branches
    clear_frame();
    fr_re[0] = 3000; fr_im[0] = 3000;
    fr_re[5] = 10;   fr_im[9] = 10;
    fr_re[12] = 100; fr_im[12] = 50;
    fr_re[13] = 100; fr_im[13] = 51;
    run_frame(256);
    check("t3_m_mag0",  64'(mag_at[0]),  64'd4500);
    check("t3_m_mag12", 64'(mag_at[12]), 64'd100);
    check("t3_m_mag13", 64'(mag_at[13]), 64'd114);
    check("t3_pk_bin",  64'(pk_bin),     64'h0905_0C0D);
    check("t3_pk_mag",  pk_mag,          64'h000A_000A_0064_0072);

    // Most-negative saturation
    clear_frame();
    fr_re[1] = -32768; fr_im[1] = -32768;
    fr_re[2] = -32768;
    fr_re[3] = -1;     fr_im[3] = 32767;
    run_frame(256);
    check("t4_m_mag1", 64'(mag_at[1]), 64'd49151);
    check("t4_m_mag2", 64'(mag_at[2]), 64'd32767);
    check("t4_pk_bin", 64'(pk_bin),    64'h0003_0201);
    check("t4_pk_mag", pk_mag,         64'h0000_7FFF_7FFF_BFFF);

    // Random backpressure: every bin exactly once with the right magnitude
    clear_frame();
    for (int i = 0; i < 256; i++) begin
      fr_re[i] = i * 100 - 12800;
      fr_im[i] = ((i * 37) % 501) - 250;
    end
    rand_en = 1'b1;
    for (int i = 0; i < 256; i++) send_bin(i);
    rand_en = 1'b0;
    tick(8);
    check("t5_beats", 64'(beats),      64'd256);
    check("t5_pkv",   64'(pkv - pkv0), 64'd1);
    for (int i = 0; i < 256; i++) begin
      check($sformatf("t5_seen%0d", i), 64'(seen[i]),   64'd1);
      check($sformatf("t5_mag%0d", i),  64'(mag_at[i]), 64'(model_mag(fr_re[i], fr_im[i])));
    end

    // Half spectrum, cfg_half changed after bin 0, stray s_last at bin 100
    clear_frame();
    fr_re[40] = 700; fr_re[200] = 5000; fr_last[100] = 1'b1;
    cfg_half = 1'b1;
    send_bin(0);
    cfg_half = 1'b0;
    for (int i = 1; i < 256; i++) send_bin(i);
    tick(8);
    check("t6_beats",   64'(beats),        64'd128);
    check("t6_seen200", 64'(seen[200]),    64'd0);
    check("t6_len_err", 64'(lerr - lerr0), 64'd1);
    check("t6_pkv",     64'(pkv - pkv0),   64'd1);
    check("t6_pk_bin",  64'(pk_bin),       64'd40);
    check("t6_pk_mag",  pk_mag,            64'd700);

    // Reset mid-frame at bin 60
    clear_frame();
    fr_re[30] = 800;
    for (int i = 0; i <= 60; i++) send_bin(i);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    check("t7_pkv",     64'(pkv - pkv0),    64'd0);
    check("t7_pk_bin",  64'(pk_bin),       64'd0);
    check("t7_pk_mag",  pk_mag,            64'd0);
    check("t7_m_valid", 64'(bus.m_valid),  64'd0);

    // Frame after reset starts at bin 0
    clear_frame();
    fr_im[7] = -250;
    run_frame(256);
    check("t8_pkv",     64'(pkv - pkv0),   64'd1);
    check("t8_len_err", 64'(lerr - lerr0), 64'd0);
    check("t8_pk_bin",  64'(pk_bin),       64'd7);
    check("t8_pk_mag",  pk_mag,            64'd250);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
